// File: rtl/adc_decimator.sv
// ADC stream decimator: keeps 1 of every D samples, frames kept samples with tlast, buffers into a FWFT FIFO.
// Define ADC_DECIM_DROP_CNT_EN to add the saturating drop_count output.
module adc_decimator #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              ul_en,
    input  logic [CNT_W-1:0]  decim_cycles,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
`ifdef ADC_DECIM_DROP_CNT_EN
    output logic [15:0]       drop_count,
`endif
    output logic              overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic              ul_en_q;
    logic [CNT_W-1:0]  ph;
    logic [CNT_W-1:0]  d_lat;
    logic [CNT_W-1:0]  fc;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic              out_valid;
    logic              out_last;
    logic [DATA_W-1:0] out_data;
    logic              ovf;

    logic              proc;
    logic              ul_rise;
    logic [CNT_W-1:0]  d_in;
    logic [CNT_W-1:0]  d_eff;
    logic              keep;
    logic              tag_last;
    logic              pop;
    logic              push;
    logic              drop;
    logic [AW-1:0]     rd_ptr_nxt;
    logic [CW-1:0]     count_nxt;
    logic              head_from_in;

    assign s_axis_tready = aresetn;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tdata  = out_data;
    assign m_axis_tlast  = out_last;
    assign overflow      = ovf;

    always_comb begin
        proc       = s_axis_tvalid && s_axis_tready && ul_en;
        ul_rise    = ul_en && !ul_en_q;
        d_in       = (decim_cycles == '0) ? CNT_W'(1) : decim_cycles;
        // The period length in force is the one captured at ph == 0
        d_eff      = (ph == '0) ? d_in : d_lat;
        keep       = proc && (ph == '0);
        tag_last   = (frame_len != '0) && (fc >= frame_len - CNT_W'(1));
        pop        = out_valid && m_axis_tready;
        push       = keep && ((count != FULL) || pop);
        drop       = keep && !push;
        rd_ptr_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
        count_nxt  = count + CW'(push) - CW'(pop);
        // New sample lands straight in the output register when nothing else is queued ahead of it
        head_from_in = push && ((count - CW'(pop)) == '0);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ul_en_q <= 1'b0;
            ph      <= '0;
            d_lat   <= '0;
            fc      <= '0;
        end else begin
            ul_en_q <= ul_en;
            if (!ul_en) begin
                ph <= '0;
                fc <= '0;
            end else if (proc) begin
                ph <= (ph == d_eff - CNT_W'(1)) ? '0 : ph + CNT_W'(1);
                if (ph == '0)
                    d_lat <= d_in;
                if (keep)
                    fc <= tag_last ? '0 : fc + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (push)
            mem[wr_ptr] <= {tag_last, s_axis_tdata};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            if (head_from_in) begin
                out_data <= s_axis_tdata;
                out_last <= tag_last;
            end else if (count_nxt != '0) begin
                out_data <= mem[rd_ptr_nxt][DATA_W-1:0];
                out_last <= mem[rd_ptr_nxt][DATA_W];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            ovf <= 1'b0;
        else
            ovf <= (ovf && !ul_rise) || drop;
    end

`ifdef ADC_DECIM_DROP_CNT_EN
    logic [15:0] drop_base;
    assign drop_base = ul_rise ? '0 : drop_count;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            drop_count <= '0;
        else if (drop && (drop_base != '1))
            drop_count <= drop_base + 16'd1;
        else
            drop_count <= drop_base;
    end
`endif

endmodule

// File: tb/tb_adc_decimator.sv
// Directed self-checking bench for adc_decimator; drop_count checks are built when ADC_DECIM_DROP_CNT_EN is defined.
module tb_adc_decimator;

    logic        aclk;
    logic        aresetn;
    logic        ul_en;
    logic [15:0] decim_cycles;
    logic [15:0] frame_len;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        overflow;
`ifdef ADC_DECIM_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    int checks   = 0;
    int failures = 0;

    logic [32:0] got_q[$];
    logic [32:0] exp_q[$];

    adc_decimator #(
        .DATA_W(32),
        .FIFO_DEPTH(16),
        .CNT_W(16)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .ul_en(ul_en),
        .decim_cycles(decim_cycles),
        .frame_len(frame_len),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
`ifdef ADC_DECIM_DROP_CNT_EN
        .drop_count(drop_count),
`endif
        .overflow(overflow)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Output handshakes are recorded mid-cycle, where inputs and outputs are settled
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready)
            got_q.push_back({m_axis_tlast, m_axis_tdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic feed(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            s_axis_tdata  = 32'(first + i);
            s_axis_tvalid = 1'b1;
            cycle();
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < n; i++)
            cycle();
    endtask

    task automatic restart();
        ul_en = 1'b0;
        idle(2);
        ul_en = 1'b1;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic add_exp(input int v, input logic last);
        exp_q.push_back({last, 32'(v)});
    endtask

    task automatic cmp_stream(input string tag);
        int n;
        chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        aresetn       = 1'b0;
        ul_en         = 1'b1;
        decim_cycles  = 16'd4;
        frame_len     = 16'd8;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        cycle();
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_m_tdata", m_axis_tdata, 32'd0);
        chk("rst_m_tlast", m_axis_tlast, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
`ifdef ADC_DECIM_DROP_CNT_EN
        chk("rst_drop_count", drop_count, 16'd0);
`endif
        aresetn = 1'b1;
        #1;
        chk("s_tready_after_rst", s_axis_tready, 1'b1);
        cycle();

        // Ramp, D=4, frame 8: first kept sample visible one cycle after its edge
        s_axis_tdata  = 32'd0;
        s_axis_tvalid = 1'b1;
        cycle();
        chk("d4_latency_valid", m_axis_tvalid, 1'b1);
        chk("d4_latency_data", m_axis_tdata, 32'd0);
        feed(1, 127);
        idle(5);
        for (int k = 0; k < 32; k++)
            add_exp(4 * k, (k % 8) == 7);
        cmp_stream("d4");
        chk("d4_overflow", overflow, 1'b0);

        // D=0 behaves as D=1
        decim_cycles = 16'd0;
        restart();
        for (int i = 0; i < 16; i++) begin
            s_axis_tdata  = 32'(i);
            s_axis_tvalid = 1'b1;
            cycle();
            chk($sformatf("d0_valid[%0d]", i), m_axis_tvalid, 1'b1);
            chk($sformatf("d0_data[%0d]", i), m_axis_tdata, 32'(i));
            chk($sformatf("d0_last[%0d]", i), m_axis_tlast, 1'((i % 8) == 7));
        end
        idle(3);
        for (int v = 0; v < 16; v++)
            add_exp(v, (v % 8) == 7);
        cmp_stream("d0");

        decim_cycles = 16'd1;
        restart();
        feed(0, 16);
        idle(3);
        for (int v = 0; v < 16; v++)
            add_exp(v, (v % 8) == 7);
        cmp_stream("d1");

        // Backpressure: 20 inputs into a 16-deep FIFO, 4 dropped, framing kept
        restart();
        m_axis_tready = 1'b0;
        feed(0, 20);
        chk("full_head_valid", m_axis_tvalid, 1'b1);
        chk("full_head_data", m_axis_tdata, 32'd0);
        chk("full_overflow", overflow, 1'b1);
`ifdef ADC_DECIM_DROP_CNT_EN
        chk("full_drop_count", drop_count, 16'd4);
`endif
        m_axis_tready = 1'b1;
        feed(20, 20);
        idle(25);
        for (int v = 0; v < 16; v++)
            add_exp(v, (v % 8) == 7);
        for (int v = 20; v < 40; v++)
            add_exp(v, (v % 8) == 7);
        cmp_stream("ovf");
        chk("ovf_sticky", overflow, 1'b1);

        // ul_en gap with D=2; counters are at 0 after the 40 kept samples above
        decim_cycles = 16'd2;
        feed(0, 10);
        ul_en = 1'b0;
        feed(10, 10);
        ul_en = 1'b1;
        feed(20, 20);
        idle(5);
        for (int v = 0; v <= 8; v += 2)
            add_exp(v, 1'b0);
        for (int v = 20; v <= 38; v += 2)
            add_exp(v, v == 34);
        cmp_stream("ulen");
        chk("ulen_overflow_cleared", overflow, 1'b0);
`ifdef ADC_DECIM_DROP_CNT_EN
        chk("ulen_drop_count_cleared", drop_count, 16'd0);
`endif

        // Asynchronous reset with 5 entries queued
        decim_cycles  = 16'd1;
        m_axis_tready = 1'b0;
        feed(0, 5);
        chk("pre_rst_valid", m_axis_tvalid, 1'b1);
        aresetn = 1'b0;
        #1;
        chk("async_rst_valid", m_axis_tvalid, 1'b0);
        chk("async_rst_tready", s_axis_tready, 1'b0);
        chk("async_rst_data", m_axis_tdata, 32'd0);
        cycle();
        chk("in_rst_tready", s_axis_tready, 1'b0);
        aresetn = 1'b1;
        got_q.delete();
        m_axis_tready = 1'b1;
        feed(16, 16);
        idle(3);
        for (int v = 16; v < 32; v++)
            add_exp(v, (v % 8) == 7);
        cmp_stream("post_rst");

        // D changed 4->2 while ph=1 applies at the next wrap
        decim_cycles = 16'd4;
        restart();
        feed(0, 1);
        decim_cycles = 16'd2;
        feed(1, 9);
        idle(3);
        add_exp(0, 1'b0);
        add_exp(4, 1'b0);
        add_exp(6, 1'b0);
        add_exp(8, 1'b0);
        cmp_stream("dchg");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adc_decimator.md
# adc_decimator

Receive-side counterpart of the DAC resampler. Accepts the continuous ADC sample stream at the interpolated rate, keeps one sample of every `decim_cycles`, frames the kept samples into OFDM symbols of `frame_len` (nfft + cp_len) with `tlast`, and buffers them in a small FIFO toward the receive chain's AXI-Stream input. It sits between the ADC capture logic and the receive FFT/CP-removal path in the ADC chain block design.

## Interface
- `DATA_W`, 32: sample width, packed `{Q[31:16], I[15:0]}`.
- `FIFO_DEPTH`, 16: output FIFO entries; must be a power of 2 and at least 2.
- `CNT_W`, 16: width of the `decim_cycles` and `frame_len` inputs and of the internal counters.

- `aclk`, in, 1: clock.
- `aresetn`, in, 1: asynchronous active-low reset.
- `ul_en`, in, 1: uplink enable; low holds counters at 0 and discards input.
- `decim_cycles`, in, CNT_W: decimation factor; 0 is treated as 1.
- `frame_len`, in, CNT_W: kept samples per frame; 0 means `tlast` is never asserted.
- `s_axis_tdata`, in, DATA_W: ADC sample.
- `s_axis_tvalid`, in, 1: sample valid.
- `s_axis_tready`, out, 1: 0 in reset, 1 otherwise. The ADC stream is never stalled.
- `m_axis_tdata`, out, DATA_W: decimated sample.
- `m_axis_tvalid`, out, 1: output valid.
- `m_axis_tready`, in, 1: downstream ready.
- `m_axis_tlast`, out, 1: last sample of a frame.
- `overflow`, out, 1: sticky flag, set when a kept sample is dropped because the FIFO is full.

## Operation
- Input is accepted when `s_axis_tvalid && s_axis_tready`. Accepted samples are processed only while `ul_en` is 1; otherwise they are discarded.
- Phase counter `ph`:
  - The sample is kept when `ph == 0`.
  - `ph` increments on every processed sample and wraps to 0 after `D-1`, where `D = max(decim_cycles, 1)`.
  - `D` is latched only when `ph == 0`. A change mid-period takes effect at the next wrap.
- Frame counter `fc`:
  - Increments on every kept sample, including samples that are dropped.
  - The kept sample is tagged `tlast` when `fc == frame_len-1` and `frame_len != 0`. `fc` then wraps to 0.
  - `frame_len` is sampled on every kept sample; if `fc >= frame_len`, the sample is tagged `tlast` and `fc` wraps.
- FIFO push (`{tlast, tdata}`):
  - A kept sample is pushed if the FIFO is not full, or is full with a pop in the same cycle.
  - Otherwise the sample is dropped and `overflow` is set to 1. A dropped `tlast` is lost; frame alignment to ADC time is preserved.
- FIFO pop occurs on `m_axis_tvalid && m_axis_tready`. The FIFO uses first-word-fall-through with registered outputs.
- `ul_en` 1→0: `ph` and `fc` clear to 0 on the next edge. FIFO contents continue to drain.
- `ul_en` 0→1: `overflow` clears and the first processed sample is kept with `fc = 0`.
- Reset mid-operation: the FIFO is emptied, all counters clear and every output goes to its reset value immediately, asynchronously.

## Timing
- Reset values:
  - `s_axis_tready`=0
  - `m_axis_tvalid`=0
  - `m_axis_tdata`=0
  - `m_axis_tlast`=0
  - `overflow`=0
  - `drop_count`=0 (when enabled)
- Latency: a kept sample accepted at edge k, with the FIFO empty, appears on `m_axis` with `tvalid`=1 in the cycle after edge k.
- Throughput: 1 sample/cycle in and out, including `D` = 1.
- `m_axis_tdata` and `m_axis_tlast` are stable while `tvalid && !tready`.
- Full: count == `FIFO_DEPTH`. Empty: `tvalid`=0. Simultaneous push and pop at full keeps count == `FIFO_DEPTH` with no drop.
- Pointers wrap modulo `FIFO_DEPTH`. Count is `$clog2(FIFO_DEPTH)+1` bits.

## Configuration
- `ADC_DECIM_DROP_CNT_EN` defined: adds output port `drop_count` (16 bits). It increments on each dropped kept sample, saturates at 0xFFFF, and clears on reset and on `ul_en` 0→1.
- Undefined: the port and counter are absent. `overflow` is unchanged.

## Test plan
- Ramp input 0,1,2,… every cycle with `decim_cycles`=4, `frame_len`=8, `m_axis_tready`=1:
  - Outputs are 0,4,8,…
  - `tlast` is set on 28, 60, 92.
  - `overflow`=0.
- Same ramp with `decim_cycles`=0, then `decim_cycles`=1: every input is output with 1-cycle latency and `tlast` on every 8th sample.
- `decim_cycles`=1, `frame_len`=8, `FIFO_DEPTH`=16, `m_axis_tready`=0 for 20 inputs, then 1:
  - Outputs are exactly inputs 0–15.
  - Next outputs are 20 onward.
  - `overflow`=1 and `drop_count`=4.
  - Frame count stays aligned, so `tlast` falls on input 23.
- `decim_cycles`=2, `frame_len`=8, `ul_en` dropped at input 10 and raised at input 20:
  - First post-enable output is 20.
  - `tlast` falls on input 34.
  - `overflow` is cleared.
- `aresetn` pulsed low for 1 cycle while the FIFO holds 5 entries:
  - `m_axis_tvalid` goes to 0 immediately; `s_axis_tready` is 0 during reset.
  - After release, the first kept sample is treated as frame index 0.
- `decim_cycles` changed 4→2 when `ph`=1: two more samples are skipped before the change applies, so the output sequence is 0,4,6,8 on a ramp.
